alu_arbiter: RTL

Sequencer and arbiter that shares the 4-bit ALU datapath between two requesters. Each requester presents two 4-bit operands and a 3-bit function code under a req/gnt handshake. The block selects one requester round-robin, captures its operands, evaluates the ALU function in a dedicated execute cycle, and returns the registered 8-bit result with a one-cycle done pulse to the winning requester. It sits between the switch/key front-end (or any two-master source) and the hex/LED display path.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu_core.sv | 37 +++
 rtl/alu_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, function codes and FSM encoding for the ALU arbiter.
package alu_pkg;

    localparam int OPW  = 4;
    localparam int FNW  = 3;
    localparam int RESW = 8;

    localparam logic [FNW-1:0] FN_RIPPLE = 3'b000;
    localparam logic [FNW-1:0] FN_ADD    = 3'b001;
    localparam logic [FNW-1:0] FN_XOR_OR = 3'b010;
    localparam logic [FNW-1:0] FN_ANY    = 3'b011;
    localparam logic [FNW-1:0] FN_ALL    = 3'b100;
    localparam logic [FNW-1:0] FN_CAT    = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester handshake bundle between the front-end masters and the shared ALU.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic            req0;
    logic            req1;
    logic [OPW-1:0]  a0;
    logic [OPW-1:0]  b0;
    logic [OPW-1:0]  a1;
    logic [OPW-1:0]  b1;
    logic [FNW-1:0]  func0;
    logic [FNW-1:0]  func1;
    logic            gnt0;
    logic            gnt1;
    logic            done0;
    logic            done1;
    logic [RESW-1:0] result;
    logic            busy;

    modport master (
        output req0, req1, a0, b0, a1, b1, func0, func1,
        input  gnt0, gnt1, done0, done1, result, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, func0, func1,
        output gnt0, gnt1, done0, done1, result, busy
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: evaluates A, B and func into the 8-bit result.
module alu_core
    import alu_pkg::*;
(
    input  logic [OPW-1:0]  a_i,
    input  logic [OPW-1:0]  b_i,
    input  logic [FNW-1:0]  func_i,
    output logic [RESW-1:0] res_o
);

    logic [OPW:0]   carry;
    logic [OPW-1:0] sum;

    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every target a default first, so no latch is inferred.
        carry = '0;
        sum   = '0;
        for (int i = 0; i < OPW; i++) begin
            sum[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    always_comb begin
        res_o = '0;
        case (func_i)
            FN_RIPPLE: res_o = {3'b000, carry[OPW], sum};
            FN_ADD:    res_o = {4'b0000, a_i} + {4'b0000, b_i};
            FN_XOR_OR: res_o = {a_i | b_i, a_i ^ b_i};
            FN_ANY:    res_o = {7'b0000000, (|a_i) | (|b_i)};
            FN_ALL:    res_o = {7'b0000000, (&a_i) & (&b_i)};
            FN_CAT:    res_o = {a_i, b_i};
            default:   res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and IDLE/EXEC/DONE sequencer sharing one ALU between two requesters.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    state_e          state_q;
    logic            last_owner_q;
    logic            owner_q;
    logic [OPW-1:0]  a_q;
    logic [OPW-1:0]  b_q;
    logic [FNW-1:0]  func_q;
    logic [RESW-1:0] result_q;
    logic            done0_q;
    logic            done1_q;
    logic            busy_q;

    logic            gnt0;
    logic            gnt1;
    logic [OPW-1:0]  a_d;
    logic [OPW-1:0]  b_d;
    logic [FNW-1:0]  func_d;
    logic [RESW-1:0] alu_res;

    // On contention the requester that did not own the last op wins.
    assign gnt0 = (state_q == ST_IDLE) && !reset && bus.req0 && (!bus.req1 || last_owner_q);
    assign gnt1 = (state_q == ST_IDLE) && !reset && bus.req1 && (!bus.req0 || !last_owner_q);

    always_comb begin
        a_d    = gnt1 ? bus.a1    : bus.a0;
        b_d    = gnt1 ? bus.b1    : bus.b0;
        func_d = gnt1 ? bus.func1 : bus.func0;
    end

    alu_core u_core (
        .a_i    (a_q),
        .b_i    (b_q),
        .func_i (func_q),
        .res_o  (alu_res)
    );

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            func_q       <= '0;
            result_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (gnt0 || gnt1) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        func_q  <= func_d;
                        owner_q <= gnt1;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q     <= alu_res;
                    last_owner_q <= owner_q;
                    done0_q      <= !owner_q;
                    done1_q      <= owner_q;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt0   = gnt0;
    assign bus.gnt1   = gnt1;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;

endmodule
